// File: rtl/pulpino_mailbox_pkg.sv
// Shared mailbox register offsets and bit indices, common to the host register block and firmware header.
package pulpino_mailbox_pkg;

  localparam logic [3:0] MBX_OFF_STATUS = 4'h0;
  localparam logic [3:0] MBX_OFF_RXDATA = 4'h4;
  localparam logic [3:0] MBX_OFF_TXDATA = 4'h8;
  localparam logic [3:0] MBX_OFF_CTRL   = 4'hC;

  typedef enum logic [1:0] {
    REG_STATUS = MBX_OFF_STATUS[3:2],
    REG_RXDATA = MBX_OFF_RXDATA[3:2],
    REG_TXDATA = MBX_OFF_TXDATA[3:2],
    REG_CTRL   = MBX_OFF_CTRL[3:2]
  } mbx_reg_e;

  // Host-driven ext flags byte
  localparam int EXT_REQ_BIT = 0;
  localparam int EXT_ACK_BIT = 1;

  // Core-driven pulpino flags byte
  localparam int PF_TX_REQ   = 0;
  localparam int PF_RX_ACK   = 1;
  localparam int PF_RX_VALID = 2;
  localparam int PF_TX_BUSY  = 3;

  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_BUSY  = 1;
  localparam int ST_OVERRUN  = 2;

  localparam int CTRL_RX_IRQ  = 0;
  localparam int CTRL_TX_IRQ  = 1;
  localparam int CTRL_OVR_IRQ = 2;

  function automatic logic [31:0] mbx_status_word(input logic rx_valid, input logic tx_busy,
                                                  input logic overrun);
    logic [31:0] w;
    w              = '0;
    w[ST_RX_VALID] = rx_valid;
    w[ST_TX_BUSY]  = tx_busy;
    w[ST_OVERRUN]  = overrun;
    return w;
  endfunction

endpackage

// File: rtl/mailbox_toggle_sync.sv
// Toggle synchroniser: pSYNC_STAGES flops plus a history flop; one-cycle event per input toggle.
module mailbox_toggle_sync #(
  parameter int pSYNC_STAGES = 2
) (
  input  logic crypto_clk,
  input  logic rst_n,
  input  logic i_tgl,
  output logic o_evt
);

  logic [pSYNC_STAGES-1:0] r_sync;
  logic                    r_hist;

  always_ff @(posedge crypto_clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[pSYNC_STAGES-2:0], i_tgl};
      r_hist <= r_sync[pSYNC_STAGES-1];
    end
  end

  assign o_evt = r_sync[pSYNC_STAGES-1] ^ r_hist;

endmodule

// File: rtl/pulpino_mailbox_apb.sv
// Core-side byte mailbox with toggle handshake to the host and a zero-wait APB slave.
// Optional interrupt output and CTRL register enabled by defining PULPINO_MAILBOX_IRQ_EN.
module pulpino_mailbox_apb
  import pulpino_mailbox_pkg::*;
#(
  parameter int pAPB_ADDR_WIDTH = 12,
  parameter int pSYNC_STAGES    = 2
) (
`ifdef PULPINO_MAILBOX_IRQ_EN
  output logic                       irq_o,
`endif
  input  logic                       crypto_clk,
  input  logic                       rst_n,
  input  logic [7:0]                 I_ext_data,
  input  logic [7:0]                 I_ext_flags,
  output logic [7:0]                 O_pulpino_data,
  output logic [7:0]                 O_pulpino_flags,
  input  logic [pAPB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]                PWDATA,
  input  logic                       PWRITE,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  output logic [31:0]                PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR
);

  logic       w_rx_evt, w_tx_ack_evt;
  mbx_reg_e   w_reg;
  logic       w_wr, w_rd, w_pop, w_tx_wr, w_tx_load, w_ovr_clr;
  logic       w_unused;

  logic [7:0] r_rx_buf, r_tx_data;
  logic       r_rx_valid, r_overrun, r_tx_busy, r_tx_req, r_rx_ack;

  mailbox_toggle_sync #(.pSYNC_STAGES(pSYNC_STAGES)) u_rx_sync (
    .crypto_clk (crypto_clk),
    .rst_n      (rst_n),
    .i_tgl      (I_ext_flags[EXT_REQ_BIT]),
    .o_evt      (w_rx_evt)
  );

  mailbox_toggle_sync #(.pSYNC_STAGES(pSYNC_STAGES)) u_tx_sync (
    .crypto_clk (crypto_clk),
    .rst_n      (rst_n),
    .i_tgl      (I_ext_flags[EXT_ACK_BIT]),
    .o_evt      (w_tx_ack_evt)
  );

  assign w_reg     = mbx_reg_e'(PADDR[3:2]);
  assign w_wr      = PSEL & PENABLE & PWRITE;
  assign w_rd      = PSEL & PENABLE & ~PWRITE;
  assign w_pop     = w_rd & (w_reg == REG_RXDATA) & r_rx_valid;
  assign w_tx_wr   = w_wr & (w_reg == REG_TXDATA);
  assign w_tx_load = w_tx_wr & ~r_tx_busy;
  assign w_ovr_clr = w_wr & (w_reg == REG_STATUS) & PWDATA[ST_OVERRUN];

  // Events and APB accesses both act on pre-edge rx_valid/tx_busy, which resolves collisions
  always_ff @(posedge crypto_clk) begin
    if (!rst_n) begin
      r_rx_buf   <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_rx_ack   <= 1'b0;
      r_tx_data  <= '0;
      r_tx_busy  <= 1'b0;
      r_tx_req   <= 1'b0;
    end else begin
      if (w_rx_evt && !r_rx_valid) begin
        r_rx_buf   <= I_ext_data;
        r_rx_valid <= 1'b1;
      end else if (w_pop) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_evt && r_rx_valid) r_overrun <= 1'b1;
      else if (w_ovr_clr)         r_overrun <= 1'b0;
      if (w_pop) r_rx_ack <= ~r_rx_ack;
      if (w_tx_load) begin
        r_tx_data <= PWDATA[7:0];
        r_tx_busy <= 1'b1;
        r_tx_req  <= ~r_tx_req;
      end else if (w_tx_ack_evt) begin
        r_tx_busy <= 1'b0;
      end
    end
  end

`ifdef PULPINO_MAILBOX_IRQ_EN
  logic [2:0] r_ctrl;
  logic       r_irq;

  always_ff @(posedge crypto_clk) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr && w_reg == REG_CTRL) r_ctrl <= PWDATA[2:0];
      r_irq <= (r_rx_valid & r_ctrl[CTRL_RX_IRQ]) | (~r_tx_busy & r_ctrl[CTRL_TX_IRQ]) |
               (r_overrun & r_ctrl[CTRL_OVR_IRQ]);
    end
  end

  assign irq_o = r_irq;
`endif

  always_comb begin
    PRDATA = '0;
    case (w_reg)
      REG_STATUS: PRDATA = mbx_status_word(r_rx_valid, r_tx_busy, r_overrun);
      REG_RXDATA: PRDATA[7:0] = r_rx_buf;
      REG_TXDATA: PRDATA = '0;
      REG_CTRL: begin
`ifdef PULPINO_MAILBOX_IRQ_EN
        PRDATA[2:0] = r_ctrl;
`else
        PRDATA = '0;
`endif
      end
      default: PRDATA = '0;
    endcase
  end

  always_comb begin
    O_pulpino_flags              = '0;
    O_pulpino_flags[PF_TX_REQ]   = r_tx_req;
    O_pulpino_flags[PF_RX_ACK]   = r_rx_ack;
    O_pulpino_flags[PF_RX_VALID] = r_rx_valid;
    O_pulpino_flags[PF_TX_BUSY]  = r_tx_busy;
  end

  assign O_pulpino_data = r_tx_data;
  assign PREADY         = 1'b1;
  assign PSLVERR        = w_tx_wr & r_tx_busy;

  assign w_unused = ^{PADDR[pAPB_ADDR_WIDTH-1:4], PADDR[1:0], PWDATA[31:8], I_ext_flags[7:2]};

endmodule

// File: tb/tb_pulpino_mailbox_apb.sv
// Self-checking bench for pulpino_mailbox_apb: directed steps plus a randomized transaction-level model.
module tb_pulpino_mailbox_apb;

  logic        crypto_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  I_ext_data, I_ext_flags;
  wire  [7:0]  O_pulpino_data, O_pulpino_flags;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  wire  [31:0] PRDATA;
  wire         PREADY, PSLVERR;
`ifdef PULPINO_MAILBOX_IRQ_EN
  wire         irq_o;
`endif

  int total = 0;
  int bad   = 0;

  // Transaction-level mailbox model
  bit       m_valid, m_ovr, m_busy, m_txreq, m_rxack;
  bit [7:0] m_buf, m_txdata;
  bit       h_req, h_ack;

  pulpino_mailbox_apb dut (
`ifdef PULPINO_MAILBOX_IRQ_EN
    .irq_o           (irq_o),
`endif
    .crypto_clk      (crypto_clk),
    .rst_n           (rst_n),
    .I_ext_data      (I_ext_data),
    .I_ext_flags     (I_ext_flags),
    .O_pulpino_data  (O_pulpino_data),
    .O_pulpino_flags (O_pulpino_flags),
    .PADDR           (PADDR),
    .PWDATA          (PWDATA),
    .PWRITE          (PWRITE),
    .PSEL            (PSEL),
    .PENABLE         (PENABLE),
    .PRDATA          (PRDATA),
    .PREADY          (PREADY),
    .PSLVERR         (PSLVERR)
  );

  always #5 crypto_clk = ~crypto_clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge crypto_clk);
    #1;
  endtask

  function automatic logic [11:0] mk_addr(input logic [1:0] idx);
    logic [31:0] r;
    r = $urandom();
    return {r[7:0], idx, r[9:8]};
  endfunction

  task automatic drive_flags;
    logic [31:0] r;
    r = $urandom();
    I_ext_flags = {r[5:0], h_ack, h_req};
  endtask

  task automatic apb(input bit wr, input logic [1:0] idx, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err);
    PADDR = mk_addr(idx); PWRITE = wr; PWDATA = wd; PSEL = 1'b1; PENABLE = 1'b0;
    tick;
    PENABLE = 1'b1;
    #1;
    rd  = PRDATA;
    err = PSLVERR;
    tick;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  function automatic logic [7:0] exp_flags();
    return {4'b0, m_busy, m_valid, m_rxack, m_txreq};
  endfunction

  function automatic logic [31:0] exp_status();
    return {29'b0, m_ovr, m_busy, m_valid};
  endfunction

  task automatic model_rx(input logic [7:0] d);
    if (m_valid) m_ovr = 1'b1;
    else begin m_buf = d; m_valid = 1'b1; end
  endtask

  task automatic model_pop;
    if (m_valid) begin m_valid = 1'b0; m_rxack = ~m_rxack; end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_flags"}, O_pulpino_flags, exp_flags());
    check({tag, "_data"}, O_pulpino_data, m_txdata);
  endtask

  task automatic rx_send(input logic [7:0] d);
    I_ext_data = d;
    h_req = ~h_req;
    drive_flags;
    model_rx(d);
    repeat (4) tick;
  endtask

  task automatic tx_ack;
    h_ack = ~h_ack;
    drive_flags;
    m_busy = 1'b0;
    repeat (4) tick;
  endtask

  task automatic tx_write(input string tag, input logic [7:0] d);
    logic [31:0] rd, r;
    logic        err;
    r = $urandom();
    apb(1'b1, 2'd2, {r[31:8], d}, rd, err);
    check({tag, "_slverr"}, err, m_busy);
    if (!m_busy) begin m_txdata = d; m_busy = 1'b1; m_txreq = ~m_txreq; end
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] rd, r;
    logic        err;
    logic [7:0]  d, d2;

    rst_n = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    I_ext_data = 0; I_ext_flags = 0; h_req = 0; h_ack = 0;
    m_valid = 0; m_ovr = 0; m_busy = 0; m_txreq = 0; m_rxack = 0; m_buf = 0; m_txdata = 0;

    // Reset with random inputs
    repeat (2) begin
      r = $urandom();
      I_ext_data = r[7:0]; I_ext_flags = r[15:8]; PADDR = r[27:16];
      PSEL = r[28]; PENABLE = r[29]; PWRITE = r[30]; PWDATA = $urandom();
      tick;
    end
    check("rst_flags", O_pulpino_flags, 0);
    check("rst_data", O_pulpino_data, 0);
    check("rst_prdata", PRDATA, 0);
    check("rst_slverr", PSLVERR, 0);
    check("rst_pready", PREADY, 1);
`ifdef PULPINO_MAILBOX_IRQ_EN
    check("rst_irq", irq_o, 0);
`endif
    PSEL = 0; PENABLE = 0; PWRITE = 0; I_ext_flags = 0;
    tick;
    rst_n = 1'b1;
    tick;
    apb(1'b0, 2'd0, 0, rd, err);
    check("rst_status", rd, 0);

    // RX latency and pop
    I_ext_data = 8'hA5; h_req = 1'b1; drive_flags; model_rx(8'hA5);
    tick; check("rx_lat_e1", O_pulpino_flags[2], 0);
    tick; check("rx_lat_e2", O_pulpino_flags[2], 0);
    tick; check("rx_lat_e3", O_pulpino_flags[2], 1);
    apb(1'b0, 2'd1, 0, rd, err);
    check("rx_pop_data", rd, 32'hA5);
    check("rx_pop_slverr", err, 0);
    model_pop;
    check_outputs("rx_pop");
    apb(1'b0, 2'd1, 0, rd, err);
    check("rx_empty_read", rd, 32'hA5);
    check_outputs("rx_empty");
    apb(1'b0, 2'd0, 0, rd, err);
    check("rx_status_after", rd, 0);

    // Overrun
    rx_send(8'h11);
    rx_send(8'h22);
    apb(1'b0, 2'd0, 0, rd, err);
    check("ovr_status", rd, 32'h5);
    apb(1'b0, 2'd1, 0, rd, err);
    check("ovr_rxdata", rd, 32'h11);
    model_pop;
    apb(1'b1, 2'd0, 32'h4, rd, err);
    m_ovr = 1'b0;
    check("ovr_clr_slverr", err, 0);
    apb(1'b0, 2'd0, 0, rd, err);
    check("ovr_status_clr", rd, 0);
    check_outputs("ovr");

    // TX
    tx_write("tx_first", 8'h3C);
    tx_write("tx_busy_rej", 8'h77);
    h_ack = ~h_ack; drive_flags;
    tick; tick; check("tx_ack_e2", O_pulpino_flags[3], 1);
    tick; check("tx_ack_e3", O_pulpino_flags[3], 0);
    m_busy = 1'b0;
    tx_ack;
    check_outputs("tx_ack_idle");
    d = 8'($urandom());
    tx_write("tx_second", d);

    // RX collision: rx_evt lands on the RXDATA pop edge
    d = 8'($urandom()); d2 = 8'($urandom());
    rx_send(d);
    I_ext_data = d2; h_req = ~h_req; drive_flags;
    tick;
    PADDR = mk_addr(2'd1); PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    tick;
    PENABLE = 1'b1;
    #1;
    check("col_rx_data", PRDATA, {24'b0, d});
    tick;
    PSEL = 0; PENABLE = 0;
    model_pop; m_ovr = 1'b1;
    check_outputs("col_rx");
    apb(1'b0, 2'd0, 0, rd, err);
    check("col_rx_status", rd, exp_status());
    apb(1'b1, 2'd0, 32'h4, rd, err);
    m_ovr = 1'b0;

    // TX collision: tx_ack_evt lands on a TXDATA write edge
    h_ack = ~h_ack; drive_flags;
    tick;
    PADDR = mk_addr(2'd2); PWRITE = 1'b1; PWDATA = 32'h000000E1; PSEL = 1'b1; PENABLE = 1'b0;
    tick;
    PENABLE = 1'b1;
    #1;
    check("col_tx_slverr", PSLVERR, 1);
    tick;
    PSEL = 0; PENABLE = 0;
    m_busy = 1'b0;
    check_outputs("col_tx");

    // Read-only writes and CTRL
    apb(1'b1, 2'd1, 32'hFF, rd, err);
    check("ro_rx_slverr", err, 0);
    apb(1'b1, 2'd0, 32'h3, rd, err);
    apb(1'b0, 2'd0, 0, rd, err);
    check("ro_status", rd, exp_status());
    apb(1'b0, 2'd2, 0, rd, err);
    check("txdata_reads0", rd, 0);
`ifdef PULPINO_MAILBOX_IRQ_EN
    apb(1'b1, 2'd3, 32'h1, rd, err);
    apb(1'b0, 2'd3, 0, rd, err);
    check("ctrl_rb", rd, 32'h1);
    check("irq_idle", irq_o, 0);
    d = 8'($urandom());
    I_ext_data = d; h_req = ~h_req; drive_flags; model_rx(d);
    tick; tick; tick;
    check("irq_e3_valid", O_pulpino_flags[2], 1);
    check("irq_e3", irq_o, 0);
    tick;
    check("irq_e4", irq_o, 1);
    apb(1'b0, 2'd1, 0, rd, err);
    model_pop;
    check("irq_pop_data", rd, {24'b0, d});
    tick;
    check("irq_after_pop", irq_o, 0);
    apb(1'b1, 2'd3, 32'h0, rd, err);
`else
    apb(1'b1, 2'd3, 32'h7, rd, err);
    check("ctrl_wr_slverr", err, 0);
    apb(1'b0, 2'd3, 0, rd, err);
    check("ctrl_reads0", rd, 0);
`endif

    // Randomized transactions against the model
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0: rx_send(8'($urandom()));
        1: begin
          apb(1'b0, 2'd1, 0, rd, err);
          check("rnd_pop", rd, {24'b0, m_buf});
          model_pop;
        end
        2: tx_write("rnd_tx", 8'($urandom()));
        3: tx_ack;
        default: begin
          apb(1'b0, 2'd0, 0, rd, err);
          check("rnd_status", rd, exp_status());
          r = $urandom();
          apb(1'b1, 2'd0, r, rd, err);
          check("rnd_w1c_slverr", err, 0);
          if (r[2]) m_ovr = 1'b0;
        end
      endcase
      check_outputs("rnd");
    end
    apb(1'b0, 2'd0, 0, rd, err);
    check("final_status", rd, exp_status());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
